// File: rtl/phase_sched.sv
// -----------------------------------------------------------------------------
// phase_sched : instruction-phase scheduler for the s_proc core.
//
// Sequences the one-hot fetch / decode / execute / increment phase strobes
// against the memory handshake. Supports multi-cycle execute, jumps that skip
// the PC increment, a resumable HALT state, and a sticky fetch-timeout error.
// Also counts retired instructions.
//
// Parameters:
//   EXW      width of ex_cycles (extra execute cycles)
//   TIMEOUT  consecutive un-acked FETCH cycles before ERR (1..255)
//   CNTW     width of instr_cnt
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   start      leave IDLE or HALT (sampled only there)
//   mem_ack    instruction word available (sampled in FETCH)
//   is_halt    decoded HALT (sampled in DECODE)
//   ex_cycles  extra execute cycles (sampled in DECODE)
//   jump       PC was loaded (sampled on the last EXEC cycle)
//   f/d/e/i    one-hot phase strobes
//   mem_req    fetch request
//   ir_load    IR capture strobe (FETCH & mem_ack)
//   pc_inc     PC increment strobe
//   halted     core is in HALT
//   mem_err    fetch timeout (sticky until clr)
//   instr_cnt  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module phase_sched #(
    parameter int EXW     = 3,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            mem_ack,
    input  logic            is_halt,
    input  logic [EXW-1:0]  ex_cycles,
    input  logic            jump,
    output logic            f,
    output logic            d,
    output logic            e,
    output logic            i,
    output logic            mem_req,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            halted,
    output logic            mem_err,
    output logic [CNTW-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_INCR   = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Timeout counter value seen on the TIMEOUT-th consecutive un-acked cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [EXW-1:0]  exec_cnt_reg;
    logic [7:0]      to_cnt_reg;
    logic [CNTW-1:0] instr_cnt_reg;

    logic exec_last;
    logic to_expire;

    assign exec_last = (state_reg == S_EXEC) && (exec_cnt_reg == '0);
    assign to_expire = (to_cnt_reg == TO_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (mem_ack)        state_next = S_DECODE;
                else if (to_expire) state_next = S_ERR;
            end
            S_DECODE: begin
                state_next = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (exec_last) state_next = jump ? S_FETCH : S_INCR;
            end
            S_INCR: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                // Resume through INCR so the PC steps past the HALT word.
                if (start) state_next = S_INCR;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        f       = 1'b0;
        d       = 1'b0;
        e       = 1'b0;
        i       = 1'b0;
        mem_req = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        halted  = 1'b0;
        mem_err = 1'b0;
        case (state_reg)
            S_FETCH: begin
                f       = 1'b1;
                mem_req = 1'b1;
                // Combinational so IR captures on the edge that leaves FETCH.
                ir_load = mem_ack;
            end
            S_DECODE: d = 1'b1;
            S_EXEC:   e = 1'b1;
            S_INCR: begin
                i      = 1'b1;
                pc_inc = 1'b1;
            end
            S_HALT:   halted  = 1'b1;
            S_ERR:    mem_err = 1'b1;
            default: ;
        endcase
    end

    assign instr_cnt = instr_cnt_reg;

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (clr) begin
            exec_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            instr_cnt_reg <= '0;
        end else begin
            // Timeout counter restarts on every entry into FETCH.
            if ((state_next == S_FETCH) && (state_reg != S_FETCH)) begin
                to_cnt_reg <= '0;
            end else if ((state_reg == S_FETCH) && !mem_ack) begin
                to_cnt_reg <= to_cnt_reg + 8'd1;
            end

            if (state_reg == S_DECODE) begin
                exec_cnt_reg <= ex_cycles;
            end else if ((state_reg == S_EXEC) && (exec_cnt_reg != '0)) begin
                exec_cnt_reg <= exec_cnt_reg - 1'b1;
            end

            if (exec_last) begin
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_sched.sv
// -----------------------------------------------------------------------------
// tb_phase_sched : directed self-checking bench for phase_sched.
// Two instances share stimulus: dut (defaults) and dut_w (CNTW=4) for wrap.
// Outputs are sampled 1 ns after the rising edge; inputs change at that time.
// Status vector = {f,d,e,i,mem_req,ir_load,pc_inc,halted,mem_err}.
// -----------------------------------------------------------------------------
module tb_phase_sched;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       mem_ack = 1'b0;
    logic       is_halt = 1'b0;
    logic [2:0] ex_cycles = 3'd0;
    logic       jump = 1'b0;

    logic        f, d, e, i, mem_req, ir_load, pc_inc, halted, mem_err;
    logic [15:0] instr_cnt;
    logic        f_w, d_w, e_w, i_w, mem_req_w, ir_load_w, pc_inc_w, halted_w, mem_err_w;
    logic [3:0]  instr_cnt_w;

    int checks = 0;
    int errors = 0;

    // Expected status vectors
    localparam logic [8:0] V_ZERO = 9'b000000000;
    localparam logic [8:0] V_FACK = 9'b100011000;
    localparam logic [8:0] V_FWAIT = 9'b100010000;
    localparam logic [8:0] V_DEC  = 9'b010000000;
    localparam logic [8:0] V_EXE  = 9'b001000000;
    localparam logic [8:0] V_INC  = 9'b000100100;
    localparam logic [8:0] V_HLT  = 9'b000000010;
    localparam logic [8:0] V_ERR  = 9'b000000001;

    always #5 clk = ~clk;

    phase_sched dut (
        .clk(clk), .clr(clr), .start(start), .mem_ack(mem_ack),
        .is_halt(is_halt), .ex_cycles(ex_cycles), .jump(jump),
        .f(f), .d(d), .e(e), .i(i), .mem_req(mem_req), .ir_load(ir_load),
        .pc_inc(pc_inc), .halted(halted), .mem_err(mem_err),
        .instr_cnt(instr_cnt)
    );

    phase_sched #(.CNTW(4)) dut_w (
        .clk(clk), .clr(clr), .start(start), .mem_ack(mem_ack),
        .is_halt(is_halt), .ex_cycles(ex_cycles), .jump(jump),
        .f(f_w), .d(d_w), .e(e_w), .i(i_w), .mem_req(mem_req_w),
        .ir_load(ir_load_w), .pc_inc(pc_inc_w), .halted(halted_w),
        .mem_err(mem_err_w), .instr_cnt(instr_cnt_w)
    );

    function automatic logic [8:0] status();
        return {f, d, e, i, mem_req, ir_load, pc_inc, halted, mem_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [8:0] exp);
        check(tag, 32'(status()), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset
        clr = 1'b1; mem_ack = 1'b1;
        step();
        clr = 1'b0;
        chk_st("reset_status", V_ZERO);
        check("reset_cnt", 32'(instr_cnt), 32'd0);

        // ---------------- 1: single-cycle instructions, ack tied high
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            chk_st("t1_f", V_FACK);
            step(); chk_st("t1_d", V_DEC);
            step(); chk_st("t1_e", V_EXE);
            check("t1_cnt_in_e", 32'(instr_cnt), 32'(n - 1));
            step(); chk_st("t1_i", V_INC);
            check("t1_cnt", 32'(instr_cnt), 32'(n));
            step();
        end
        // now in FETCH, cnt=2

        // ---------------- 2: ex_cycles=3 -> four EXEC cycles
        ex_cycles = 3'd3;
        chk_st("t2_f", V_FACK);
        step(); chk_st("t2_d", V_DEC);
        for (int k = 0; k < 4; k++) begin
            step(); chk_st("t2_e", V_EXE);
            check("t2_cnt_hold", 32'(instr_cnt), 32'd2);
        end
        step(); chk_st("t2_i", V_INC);
        check("t2_cnt", 32'(instr_cnt), 32'd3);

        // ---------------- 3: jump on last EXEC cycle skips INCR
        ex_cycles = 3'd1; jump = 1'b1;
        step(); chk_st("t3_f", V_FACK);
        step(); chk_st("t3_d", V_DEC);
        step(); chk_st("t3_e1", V_EXE);
        step(); chk_st("t3_e2", V_EXE);
        step(); chk_st("t3_f_after_jump", V_FACK);
        check("t3_cnt", 32'(instr_cnt), 32'd4);
        jump = 1'b0; ex_cycles = 3'd0;

        // ---------------- 4a: five wait cycles then ack -> six f cycles
        step(); chk_st("t4_d", V_DEC);
        step(); chk_st("t4_e", V_EXE);
        step(); chk_st("t4_i", V_INC);
        mem_ack = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            mem_ack = (k == 6);
            #0;
            chk_st("t4_wait_f", (k == 6) ? V_FACK : V_FWAIT);
        end
        step(); chk_st("t4_wait_d", V_DEC);

        // ---------------- 4b: ack in the 15th cycle still wins
        step(); chk_st("t4b_e", V_EXE);
        step(); chk_st("t4b_i", V_INC);
        check("t4b_cnt", 32'(instr_cnt), 32'd6);
        mem_ack = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            mem_ack = (k == 15);
            #0;
            chk_st("t4b_f", (k == 15) ? V_FACK : V_FWAIT);
        end
        step(); chk_st("t4b_d", V_DEC);

        // ---------------- 4c: no ack -> ERR after 15 f cycles, sticky
        step(); chk_st("t4c_e", V_EXE);
        step(); chk_st("t4c_i", V_INC);
        mem_ack = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step(); chk_st("t4c_f", V_FWAIT);
        end
        step(); chk_st("t4c_err", V_ERR);
        start = 1'b1; mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_st("t4c_err_sticky", V_ERR);
        end
        start = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_st("t4c_clr", V_ZERO);
        check("t4c_clr_cnt", 32'(instr_cnt), 32'd0);

        // ---------------- 5: HALT and resume
        start = 1'b1; is_halt = 1'b1; ex_cycles = 3'd5;
        step(); start = 1'b0;
        chk_st("t5_f", V_FACK);
        step(); chk_st("t5_d", V_DEC);
        step(); is_halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk_st("t5_halt", V_HLT);
            check("t5_cnt", 32'(instr_cnt), 32'd0);
            step();
        end
        start = 1'b1;
        step(); start = 1'b0;
        chk_st("t5_resume_i", V_INC);
        step(); chk_st("t5_resume_f", V_FACK);

        // ---------------- 6a: clr during 2nd of 4 EXEC cycles
        ex_cycles = 3'd3;
        step(); chk_st("t6_d", V_DEC);
        step(); chk_st("t6_e1", V_EXE);
        step(); chk_st("t6_e2", V_EXE);
        clr = 1'b1;
        step(); clr = 1'b0;
        chk_st("t6_clr_status", V_ZERO);
        check("t6_clr_cnt", 32'(instr_cnt), 32'd0);
        step(); chk_st("t6_idle", V_ZERO);

        // ---------------- 6b: 16 jump instructions -> 4-bit counter wraps
        ex_cycles = 3'd0; jump = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step(); step(); step();
            check("t6_wrap_cnt16", 32'(instr_cnt), 32'(n));
            check("t6_wrap_cnt4", 32'(instr_cnt_w), 32'(n % 16));
        end
        chk_st("t6_wrap_f", V_FACK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
